// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: request/response bus between the fetch path and the SPI flash reader.
//   req_valid/req_ready : request handshake, transfer when both are high
//   req_addr            : flash byte address; bits [1:0] are ignored
//   rsp_valid           : one-cycle pulse, rsp_data carries the word
//   rsp_data            : little-endian word, lowest-address byte in [7:0]
// master = requester (core side), slave = spi_flash_reader.
interface spi_flash_reader_if;
    logic        req_valid;
    logic [23:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-lane SPI (mode 0) flash read initiator using the READ (0x03) command.
// Returns 32-bit little-endian words; a request for the next sequential word while the burst
// is still open (HOLD) continues clocking data without re-sending command and address.
// Ports:
//   core_clk     : system clock, rising edge
//   core_rstn    : synchronous active-low reset
//   bus          : request/response handshake (spi_flash_reader_if.slave)
//   flash_csb    : flash chip select, active low
//   flash_clk    : SPI clock, idle low
//   flash_io0_do : MOSI
//   flash_io1_di : MISO
module spi_flash_reader #(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned CSB_HIGH_MIN = 2,
    parameter int unsigned HOLD_TIMEOUT = 16
) (
    input  logic              core_clk,
    input  logic              core_rstn,
    spi_flash_reader_if.slave bus,
    output logic              flash_csb,
    output logic              flash_clk,
    output logic              flash_io0_do,
    input  logic              flash_io1_di
);
    localparam logic [7:0]  READ_CMD  = 8'h03;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] CSBH_LAST = 16'(CSB_HIGH_MIN - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StCsbh, StCmd, StAddr, StData, StHold} state_e;

    state_e      state_q;
    logic [15:0] div_cnt_q;
    logic [15:0] csbh_cnt_q;
    logic [15:0] hold_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [31:0] tx_shift_q;
    logic [31:0] rx_shift_q;
    // Word address being fetched; once DATA completes it holds the next sequential address.
    logic [23:0] addr_q;
    // Set when CSBH was entered for a latched restart rather than a timeout.
    logic        restart_q;

    logic        accept;
    logic        seq_hit;
    logic        phase_end;
    logic [23:0] req_word_addr;
    logic        unused_addr_lsb;

    assign req_word_addr   = {bus.req_addr[23:2], 2'b00};
    assign unused_addr_lsb = ^bus.req_addr[1:0];
    assign accept          = bus.req_valid & bus.req_ready;
    // A wrapped next address (0) must restart with a fresh command.
    assign seq_hit         = (bus.req_addr[23:2] == addr_q[23:2]) && (addr_q != 24'h0);
    assign phase_end       = (div_cnt_q == DIV_LAST);

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state_q       <= StIdle;
            flash_csb     <= 1'b1;
            flash_clk     <= 1'b0;
            flash_io0_do  <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.req_ready <= 1'b0;
            csbh_cnt_q    <= '0;  // zero means the CSB-high minimum is already served
            div_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            addr_q        <= '0;
            restart_q     <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    flash_csb <= 1'b1;
                    flash_clk <= 1'b0;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        addr_q        <= req_word_addr;
                        state_q       <= StCmd;
                        flash_csb     <= 1'b0;
                        tx_shift_q    <= {READ_CMD, req_word_addr};
                        flash_io0_do  <= READ_CMD[7];
                        bit_cnt_q     <= 5'd31;
                        div_cnt_q     <= '0;
                    end else begin
                        bus.req_ready <= (csbh_cnt_q == '0);
                    end
                end
                StCsbh: begin
                    if (csbh_cnt_q != '0) begin
                        csbh_cnt_q <= csbh_cnt_q - 16'd1;
                    end else if (restart_q) begin
                        restart_q    <= 1'b0;
                        state_q      <= StCmd;
                        flash_csb    <= 1'b0;
                        tx_shift_q   <= {READ_CMD, addr_q};
                        flash_io0_do <= READ_CMD[7];
                        bit_cnt_q    <= 5'd31;
                        div_cnt_q    <= '0;
                    end else begin
                        state_q       <= StIdle;
                        bus.req_ready <= 1'b1;
                    end
                end
                StCmd, StAddr: begin
                    if (!phase_end) begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end else begin
                        div_cnt_q <= '0;
                        flash_clk <= ~flash_clk;
                        // End of the high phase: present the next bit while clk is low.
                        if (flash_clk) begin
                            tx_shift_q   <= {tx_shift_q[30:0], 1'b0};
                            flash_io0_do <= tx_shift_q[30];
                            bit_cnt_q    <= bit_cnt_q - 5'd1;
                            if (bit_cnt_q == 5'd24) begin
                                state_q <= StAddr;
                            end
                            if (bit_cnt_q == 5'd0) begin
                                state_q      <= StData;
                                flash_io0_do <= 1'b0;
                            end
                        end
                    end
                end
                StData: begin
                    if (!phase_end) begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end else begin
                        div_cnt_q <= '0;
                        flash_clk <= ~flash_clk;
                        if (!flash_clk) begin
                            rx_shift_q <= {rx_shift_q[30:0], flash_io1_di};
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 5'd1;
                            if (bit_cnt_q == 5'd0) begin
                                state_q       <= StHold;
                                bus.rsp_valid <= 1'b1;
                                // First byte received is the lowest address.
                                bus.rsp_data  <= {rx_shift_q[7:0], rx_shift_q[15:8],
                                                  rx_shift_q[23:16], rx_shift_q[31:24]};
                                addr_q        <= addr_q + 24'd4;
                                hold_cnt_q    <= '0;
                                bus.req_ready <= 1'b1;
                            end
                        end
                    end
                end
                StHold: begin
                    // A request in the timeout cycle takes precedence over the timeout.
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        if (seq_hit) begin
                            state_q   <= StData;
                            bit_cnt_q <= 5'd31;
                            div_cnt_q <= '0;
                        end else begin
                            state_q    <= StCsbh;
                            flash_csb  <= 1'b1;
                            csbh_cnt_q <= CSBH_LAST;
                            restart_q  <= 1'b1;
                            addr_q     <= req_word_addr;
                        end
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q       <= StCsbh;
                        flash_csb     <= 1'b1;
                        csbh_cnt_q    <= CSBH_LAST;
                        restart_q     <= 1'b0;
                        bus.req_ready <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule
